parking_controller: RTL and testbench
=====================================

PARKING_CONTROLLER -- requirements
Module: parking_controller

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- TIME_WIDTH, 16, timestamp width
- COST_WIDTH, 16, cost width
- CAPACITY, 3, slots in the timestamp buffer
- GATE_CYCLES, 4, cycles a gate stays open
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge
- rst, in, 1, reset, synchronous and active-high
- entry_req, in, 1, car at entry sensor (level)
- exit_req, in, 1, car at exit sensor (level)
- global_time, in, TIME_WIDTH, free-running time
- rate, in, 8, cost per time unit
- buf_count, in, 2, occupancy reported by timestamp buffer
- oldest_time, in, TIME_WIDTH, buffer output, valid the cycle after buf_pop
- pay_ack, in, 1, payment accepted
- buf_push, out, 1, one-cycle push strobe to buffer
- buf_pop, out, 1, one-cycle pop strobe to buffer
- entry_gate, out, 1, entry barrier open
- exit_gate, out, 1, exit barrier open
- full, out, 1, buf_count == CAPACITY
- cost, out, COST_WIDTH, fee for the exiting car
- cost_valid, out, 1, cost held, awaiting pay_ack
- busy, out, 1, FSM not in IDLE

Function
REQ-003 FSM states SHALL be IDLE, ENTRY_PUSH, ENTRY_OPEN, EXIT_POP, EXIT_BILL, EXIT_PAY, EXIT_OPEN.
REQ-004 IDLE: a request is eligible only when entry_req && !full (entry) or exit_req && buf_count != 0 (exit); an ineligible request SHALL be ignored with no strobe.
REQ-005 IDLE with one eligible request SHALL go to ENTRY_PUSH or EXIT_POP the next cycle.
REQ-006 Both eligible in the same cycle: exit SHALL win (default arbitration; see REQ-017).
REQ-007 ENTRY_PUSH SHALL assert buf_push for exactly one cycle and then go to ENTRY_OPEN.
REQ-008 ENTRY_OPEN SHALL assert entry_gate for GATE_CYCLES cycles and then go to IDLE.
REQ-009 EXIT_POP SHALL assert buf_pop for exactly one cycle and then go to EXIT_BILL.
REQ-010 EXIT_BILL SHALL capture the following, then go to EXIT_PAY:
- duration = (global_time - oldest_time) mod 2^TIME_WIDTH; wrap is legal, not zero
- cost = duration*rate, computed at TIME_WIDTH+8 bits and saturated to all-ones if it exceeds COST_WIDTH
REQ-011 EXIT_PAY SHALL hold cost and cost_valid=1 until pay_ack, then go to EXIT_OPEN with cost_valid=0 the next cycle; pay_ack outside EXIT_PAY SHALL be ignored.
REQ-012 EXIT_OPEN SHALL assert exit_gate for GATE_CYCLES cycles and then go to IDLE.
REQ-013 buf_push and buf_pop SHALL never be asserted in the same cycle; at most one transaction is in flight.
REQ-014 full and busy SHALL be combinational from buf_count and state; requests arriving while busy SHALL be ignored, not queued.

Reset
REQ-015 On rst at any clock edge, including mid-transaction, the FSM SHALL enter IDLE and all strobes, gates, cost, cost_valid and the gate counter SHALL be 0 the following cycle.
REQ-016 Buffer occupancy SHALL NOT be rebuilt by this block; the system resets the buffer together with it.

Configuration
REQ-017 Macro PARK_RR_ARB_EN:
- defined: simultaneous eligible requests SHALL alternate via a 1-bit last-grant flag (reset value: last=exit, so entry wins first)
- undefined: exit SHALL always win

Structure
REQ-018 A shared package SHALL hold the FSM state enum, TIME_WIDTH/COST_WIDTH defaults and the saturating-multiply width constant.
REQ-019 One sub-module, park_gate_timer (load, count down GATE_CYCLES, done pulse), SHALL serve both gates.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Entry at count=0 -> buf_push one cycle later for 1 cycle; entry_gate high 4 cycles.
- Entry with buf_count=3 -> no buf_push, entry_gate stays 0, full=1.
- Exit with oldest_time=10, global_time=25, rate=3 -> cost=45, cost_valid until pay_ack, then exit_gate for 4 cycles.
- Wrap case with oldest_time=0xFFF0, global_time=0x0010, rate=2 -> cost=64; rate=255 with duration=0x1000 -> cost=0xFFFF.
- Simultaneous entry_req and exit_req, repeated twice -> exit then exit (macro off); entry then exit (PARK_RR_ARB_EN).
- rst in EXIT_PAY -> next cycle IDLE, cost_valid=0, cost=0, exit_gate=0.

Source files
------------

// File: rtl/parking_controller_pkg.sv
// rtl/parking_controller_pkg.sv - shared FSM state type and width defaults for the parking controller
package parking_controller_pkg;

  localparam int TIME_WIDTH_DEF = 16;
  localparam int COST_WIDTH_DEF = 16;
  localparam int RATE_WIDTH     = 8;
  localparam int MUL_WIDTH_DEF  = TIME_WIDTH_DEF + RATE_WIDTH;

  // Product of a duration and a rate never exceeds this many bits
  function automatic int mul_width(input int time_width);
    return time_width + RATE_WIDTH;
  endfunction

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ENTRY_PUSH = 3'd1,
    ENTRY_OPEN = 3'd2,
    EXIT_POP   = 3'd3,
    EXIT_BILL  = 3'd4,
    EXIT_PAY   = 3'd5,
    EXIT_OPEN  = 3'd6
  } park_state_t;

endpackage

// File: rtl/park_gate_timer.sv
// rtl/park_gate_timer.sv - gate hold timer shared by entry and exit barriers
// done pulses in the last cycle of a CYCLES-long window started by load
module park_gate_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CW'(1));

endmodule

// File: rtl/parking_controller.sv
// rtl/parking_controller.sv - parking entry/exit sequencer with billing; PARK_RR_ARB_EN selects
// round-robin arbitration of simultaneous requests (default: exit always wins)
module parking_controller
  import parking_controller_pkg::*;
#(
  parameter int TIME_WIDTH  = TIME_WIDTH_DEF,
  parameter int COST_WIDTH  = COST_WIDTH_DEF,
  parameter int CAPACITY    = 3,
  parameter int GATE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  entry_req,
  input  logic                  exit_req,
  input  logic [TIME_WIDTH-1:0] global_time,
  input  logic [RATE_WIDTH-1:0] rate,
  input  logic [1:0]            buf_count,
  input  logic [TIME_WIDTH-1:0] oldest_time,
  input  logic                  pay_ack,
  output logic                  buf_push,
  output logic                  buf_pop,
  output logic                  entry_gate,
  output logic                  exit_gate,
  output logic                  full,
  output logic [COST_WIDTH-1:0] cost,
  output logic                  cost_valid,
  output logic                  busy
);

  localparam int MUL_W = mul_width(TIME_WIDTH);

  park_state_t           state;
  logic                  elig_entry, elig_exit, exit_first;
  logic                  grant_entry, grant_exit;
  logic                  timer_load, gate_done;
  logic [TIME_WIDTH-1:0] duration;
  logic [MUL_W-1:0]      product;
  logic                  overflow;
  logic [COST_WIDTH-1:0] cost_next;

  assign full = (buf_count == 2'(CAPACITY));
  assign busy = (state != IDLE);

  assign elig_entry = entry_req && !full;
  assign elig_exit  = exit_req && (buf_count != 2'd0);

`ifdef PARK_RR_ARB_EN
  logic last_exit;
  assign exit_first = !last_exit;
`else
  assign exit_first = 1'b1;
`endif

  assign grant_exit  = elig_exit && (!elig_entry || exit_first);
  assign grant_entry = elig_entry && !grant_exit;

  // Wrap of global_time past oldest_time is a legal, non-zero stay
  assign duration  = global_time - oldest_time;
  assign product   = MUL_W'(duration) * MUL_W'(rate);
  assign overflow  = ((product >> COST_WIDTH) != '0);
  assign cost_next = overflow ? '1 : COST_WIDTH'(product);

  assign timer_load = (state == ENTRY_PUSH) || ((state == EXIT_PAY) && pay_ack);

  park_gate_timer #(
    .CYCLES (GATE_CYCLES)
  ) u_gate_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .done (gate_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      buf_push   <= 1'b0;
      buf_pop    <= 1'b0;
      entry_gate <= 1'b0;
      exit_gate  <= 1'b0;
      cost       <= '0;
      cost_valid <= 1'b0;
`ifdef PARK_RR_ARB_EN
      last_exit  <= 1'b1;
`endif
    end else begin
      buf_push <= 1'b0;
      buf_pop  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_exit) begin
            state   <= EXIT_POP;
            buf_pop <= 1'b1;
          end else if (grant_entry) begin
            state    <= ENTRY_PUSH;
            buf_push <= 1'b1;
          end
`ifdef PARK_RR_ARB_EN
          if (grant_exit)       last_exit <= 1'b1;
          else if (grant_entry) last_exit <= 1'b0;
`endif
        end
        ENTRY_PUSH: begin
          state      <= ENTRY_OPEN;
          entry_gate <= 1'b1;
        end
        ENTRY_OPEN: begin
          if (gate_done) begin
            state      <= IDLE;
            entry_gate <= 1'b0;
          end
        end
        // oldest_time becomes valid while in EXIT_BILL
        EXIT_POP: state <= EXIT_BILL;
        EXIT_BILL: begin
          state      <= EXIT_PAY;
          cost       <= cost_next;
          cost_valid <= 1'b1;
        end
        EXIT_PAY: begin
          if (pay_ack) begin
            state      <= EXIT_OPEN;
            cost_valid <= 1'b0;
            exit_gate  <= 1'b1;
          end
        end
        EXIT_OPEN: begin
          if (gate_done) begin
            state     <= IDLE;
            exit_gate <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_controller.sv
// tb/tb_parking_controller.sv - scoreboard bench for parking_controller (honours PARK_RR_ARB_EN)
module tb_parking_controller;

  localparam int K_PUSH  = 0;
  localparam int K_POP   = 1;
  localparam int K_COST  = 2;
  localparam int K_EGATE = 3;
  localparam int K_XGATE = 4;

  typedef struct {
    int kind;
    int value;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        entry_req = 1'b0;
  logic        exit_req = 1'b0;
  logic        pay_ack = 1'b0;
  logic [15:0] global_time = '0;
  logic [15:0] oldest_time = '0;
  logic [7:0]  rate = '0;
  logic [1:0]  buf_count = '0;
  logic        buf_push, buf_pop, entry_gate, exit_gate, full, cost_valid, busy;
  logic [15:0] cost;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  req_cyc = 0;

  always #5 clk = ~clk;

  parking_controller #(
    .TIME_WIDTH  (16),
    .COST_WIDTH  (16),
    .CAPACITY    (3),
    .GATE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .global_time (global_time),
    .rate        (rate),
    .buf_count   (buf_count),
    .oldest_time (oldest_time),
    .pay_ack     (pay_ack),
    .buf_push    (buf_push),
    .buf_pop     (buf_pop),
    .entry_gate  (entry_gate),
    .exit_gate   (exit_gate),
    .full        (full),
    .cost        (cost),
    .cost_valid  (cost_valid),
    .busy        (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_check(input int kind, input int value);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind %0d value %0d expected nothing", kind, value);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.value != value) begin
        errors++;
        $display("FAIL sb_event: got kind %0d value %0d expected kind %0d value %0d",
                 kind, value, e.kind, e.value);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and checks them against the queue
  int   egate_run = 0;
  int   xgate_run = 0;
  logic prev_cv = 1'b0;
  always @(negedge clk) begin
    if (buf_push === 1'b1 && buf_pop === 1'b1) chk("push_pop_overlap", 1, 0);
    if (buf_push === 1'b1) sb_check(K_PUSH, cyc - req_cyc);
    if (buf_pop === 1'b1)  sb_check(K_POP, cyc - req_cyc);
    if (cost_valid === 1'b1 && !prev_cv) sb_check(K_COST, int'(cost));
    prev_cv = (cost_valid === 1'b1);
    if (entry_gate === 1'b1) egate_run++;
    else if (egate_run > 0) begin
      sb_check(K_EGATE, egate_run);
      egate_run = 0;
    end
    if (exit_gate === 1'b1) xgate_run++;
    else if (xgate_run > 0) begin
      sb_check(K_XGATE, xgate_run);
      xgate_run = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int kind, input int value);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic expect_exit(input int c);
    expect_ev(K_POP, 1);
    expect_ev(K_COST, c);
    expect_ev(K_XGATE, 4);
  endtask

  task automatic start_req(input bit en, input bit ex);
    req_cyc   = cyc;
    entry_req = en;
    exit_req  = ex;
    tick();
    entry_req = 1'b0;
    exit_req  = 1'b0;
  endtask

  task automatic wait_cost(input string name);
    int i = 0;
    while (cost_valid !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    if (cost_valid !== 1'b1) chk({name, "_cost_timeout"}, 0, 1);
  endtask

  // Pays any pending bill and waits for the FSM to return to IDLE
  task automatic wait_idle(input string name);
    int i = 0;
    while (busy !== 1'b0 && i < 60) begin
      if (cost_valid === 1'b1) begin
        pay_ack = 1'b1;
        tick();
        pay_ack = 1'b0;
      end else begin
        tick();
      end
      i++;
    end
    if (busy !== 1'b0) chk({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic set_exit(input int o, input int g, input int r);
    oldest_time = 16'(o);
    global_time = 16'(g);
    rate        = 8'(r);
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_push", int'(buf_push), 0);
    chk("rst_pop", int'(buf_pop), 0);
    chk("rst_cost_valid", int'(cost_valid), 0);
    chk("rst_cost", int'(cost), 0);
    chk("rst_gates", int'({entry_gate, exit_gate}), 0);
    chk("rst_full", int'(full), 0);

    // Entry into an empty lot
    expect_ev(K_PUSH, 1);
    expect_ev(K_EGATE, 4);
    start_req(1'b1, 1'b0);
    chk("entry_busy", int'(busy), 1);
    wait_idle("entry");

    // Full lot: entry refused
    buf_count = 2'd2;
    tick();
    chk("full_at_2", int'(full), 0);
    buf_count = 2'd3;
    tick();
    chk("full_at_3", int'(full), 1);
    entry_req = 1'b1;
    tick(3);
    entry_req = 1'b0;
    chk("full_no_busy", int'(busy), 0);
    chk("full_no_gate", int'(entry_gate), 0);

    // Exit refused with an empty buffer; stray pay_ack while idle is ignored
    buf_count = 2'd0;
    exit_req  = 1'b1;
    pay_ack   = 1'b1;
    tick(2);
    exit_req  = 1'b0;
    pay_ack   = 1'b0;
    chk("empty_exit_ignored", int'(busy), 0);

    // Basic exit: 15 units at rate 3
    buf_count = 2'd1;
    set_exit(10, 25, 3);
    expect_exit(45);
    start_req(1'b0, 1'b1);
    chk("exit_busy", int'(busy), 1);
    wait_cost("exit");
    tick(3);
    chk("cost_held_valid", int'(cost_valid), 1);
    chk("cost_held_value", int'(cost), 45);
    chk("gate_closed_unpaid", int'(exit_gate), 0);
    wait_idle("exit");

    // Time wrap: 0xFFF0 -> 0x0010 is 32 units
    set_exit(16'hFFF0, 16'h0010, 2);
    expect_exit(64);
    start_req(1'b0, 1'b1);
    wait_idle("wrap");

    // Saturation: 0x1000 * 255 exceeds 16 bits
    set_exit(0, 16'h1000, 255);
    expect_exit(16'hFFFF);
    start_req(1'b0, 1'b1);
    wait_idle("sat");

    // Simultaneous requests, twice
    set_exit(10, 25, 3);
`ifdef PARK_RR_ARB_EN
    expect_ev(K_PUSH, 1);
    expect_ev(K_EGATE, 4);
`else
    expect_exit(45);
`endif
    start_req(1'b1, 1'b1);
    wait_idle("both1");
    expect_exit(45);
    start_req(1'b1, 1'b1);
    wait_idle("both2");

    // Reset while waiting for payment
    expect_ev(K_POP, 1);
    expect_ev(K_COST, 45);
    start_req(1'b0, 1'b1);
    wait_cost("rstpay");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstpay_busy", int'(busy), 0);
    chk("rstpay_cost_valid", int'(cost_valid), 0);
    chk("rstpay_cost", int'(cost), 0);
    chk("rstpay_exit_gate", int'(exit_gate), 0);
    tick(6);
    chk("rstpay_gate_stays", int'(exit_gate), 0);

    tick(2);
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
